// File: rtl/drive_cmd_arbiter.sv
// rtl/drive_cmd_arbiter.sv - mode-selecting command arbiter with dead-time, reversal gap, interlock and aux pulsing
//
// Selects one of N_MODES command channels and drives the device command from it.
// Channel 0 is the OFF channel and always produces an all-zero command.
// Command bits: [0] forward, [1] backward, [2] left, [3] right, [CMD_W-1:4] aux.
//
// Ports:
//   clk          - divided system clock
//   reset        - asynchronous, active-high reset
//   mode_sel     - requested mode index (values >= N_MODES select channel 0)
//   cmd_in       - packed channel commands, channel k at [k*CMD_W +: CMD_W]
//   cmd_out      - registered command to the device
//   active_mode  - mode currently driving cmd_out
//   switching    - high while the mode-change dead time is running
//   conflict_cnt - saturating count of cycles containing an opposing-command conflict
module drive_cmd_arbiter #(
  parameter int N_MODES     = 4,
  parameter int SEL_W       = 2,
  parameter int CMD_W       = 6,
  parameter int DEAD_CYCLES = 4,
  parameter int REV_GAP     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         mode_sel,
  input  logic [N_MODES*CMD_W-1:0] cmd_in,
  output logic [CMD_W-1:0]         cmd_out,
  output logic [SEL_W-1:0]         active_mode,
  output logic                     switching,
  output logic [7:0]               conflict_cnt
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DEAD = 1'b1;

  // Counters keep at least one bit so zero-length gaps still elaborate.
  localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam int RW = (REV_GAP > 0) ? $clog2(REV_GAP + 1) : 1;

  // Aux field mask; the low four motion bits are never part of aux_prev.
  localparam logic [CMD_W-1:0] AUX_MASK = {CMD_W{1'b1}} << 4;

  logic [0:0]       state;
  logic [SEL_W-1:0] target;
  logic [DW-1:0]    dead_cnt;
  logic [RW-1:0]    rev_cnt;
  logic [CMD_W-1:0] aux_prev;

  logic [SEL_W-1:0] eff_sel;
  logic [SEL_W-1:0] run_sel;
  logic [CMD_W-1:0] req;
  logic [CMD_W-1:0] tgt_req;
  logic [CMD_W-1:0] run_cmd;
  logic [RW-1:0]    rev_next;
  logic             fwd, bwd, left, right;
  logic             any_conflict;
  logic             rev_start;

  // Out-of-range selections collapse onto the OFF channel.
  assign eff_sel = ({1'b0, mode_sel} < (SEL_W+1)'(N_MODES)) ? mode_sel : '0;

  // With no dead time a mode change takes effect on the same edge, so the
  // requested channel drives the output directly.
  assign run_sel = (DEAD_CYCLES == 0) ? eff_sel : active_mode;

  always_comb begin
    req     = '0;
    tgt_req = '0;
    for (int k = 0; k < N_MODES; k++) begin
      if (run_sel == SEL_W'(k)) req = cmd_in[k*CMD_W +: CMD_W];
      if (target == SEL_W'(k))  tgt_req = cmd_in[k*CMD_W +: CMD_W];
    end
    if (run_sel == '0) req = '0;
    if (target == '0)  tgt_req = '0;

    fwd   = req[0];
    bwd   = req[1];
    left  = req[2];
    right = req[3];

    any_conflict = (fwd & bwd) | (left & right);

    // A reversal is a currently-driven direction facing a request for the
    // opposite direction alone.
    rev_start = (REV_GAP > 0) &&
                ((cmd_out[0] && bwd && !fwd) || (cmd_out[1] && fwd && !bwd));

    run_cmd    = '0;
    run_cmd[0] = fwd & ~bwd;
    run_cmd[1] = bwd & ~fwd;
    run_cmd[2] = left & ~right;
    run_cmd[3] = right & ~left;
    // Aux bits pulse for one cycle on each rising edge of the request.
    run_cmd    = run_cmd | (req & ~aux_prev & AUX_MASK);

    rev_next = rev_cnt;
    if (rev_start) begin
      run_cmd[1:0] = 2'b00;
      rev_next     = RW'(REV_GAP);
    end else if (rev_cnt != '0) begin
      run_cmd[1:0] = 2'b00;
      rev_next     = rev_cnt - RW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      target       <= '0;
      dead_cnt     <= '0;
      rev_cnt      <= '0;
      aux_prev     <= '0;
      cmd_out      <= '0;
      active_mode  <= '0;
      switching    <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if ((eff_sel != active_mode) && (DEAD_CYCLES > 0)) begin
            state     <= ST_DEAD;
            switching <= 1'b1;
            target    <= eff_sel;
            dead_cnt  <= DW'(DEAD_CYCLES);
            cmd_out   <= '0;
          end else begin
            active_mode <= run_sel;
            cmd_out     <= run_cmd;
            rev_cnt     <= rev_next;
            aux_prev    <= req & AUX_MASK;
            if (any_conflict && (conflict_cnt != 8'hFF))
              conflict_cnt <= conflict_cnt + 8'd1;
          end
        end
        ST_DEAD: begin
          cmd_out <= '0;
          if (eff_sel != target) begin
            // Retargeting restarts the full dead time.
            target   <= eff_sel;
            dead_cnt <= DW'(DEAD_CYCLES);
          end else if (dead_cnt == DW'(1)) begin
            state       <= ST_RUN;
            switching   <= 1'b0;
            active_mode <= target;
            rev_cnt     <= '0;
            // Seed with the held aux level so it does not pulse on entry.
            aux_prev    <= tgt_req & AUX_MASK;
          end else begin
            dead_cnt <= dead_cnt - DW'(1);
          end
        end
        default: begin
          state     <= ST_RUN;
          switching <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// tb/tb_drive_cmd_arbiter.sv - self-checking bench for drive_cmd_arbiter
module tb_drive_cmd_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  mode_sel;
  logic [2:0]  mode_sel3;
  logic [23:0] cmd_in;

  logic [5:0]  cmd_out0, cmd_out3;
  logic [1:0]  active0;
  logic [2:0]  active3;
  logic        sw0, sw3;
  logic [7:0]  cc0, cc3;

  int checks   = 0;
  int failures = 0;

  drive_cmd_arbiter #(
    .N_MODES(4), .SEL_W(2), .CMD_W(6), .DEAD_CYCLES(4), .REV_GAP(2)
  ) u_dut (
    .clk(clk), .reset(reset), .mode_sel(mode_sel), .cmd_in(cmd_in),
    .cmd_out(cmd_out0), .active_mode(active0), .switching(sw0), .conflict_cnt(cc0)
  );

  drive_cmd_arbiter #(
    .N_MODES(4), .SEL_W(3), .CMD_W(6), .DEAD_CYCLES(0), .REV_GAP(0)
  ) u_dut3 (
    .clk(clk), .reset(reset), .mode_sel(mode_sel3), .cmd_in(cmd_in),
    .cmd_out(cmd_out3), .active_mode(active3), .switching(sw3), .conflict_cnt(cc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int in_dead;
    int target;
    int dead_cnt;
    int rev_cnt;
    int aux_prev;
    int cmd_out;
    int active;
    int switching;
    int conflict;
  } mst_t;

  mst_t m0, m1;

  function automatic int chan(input logic [23:0] cin, input int ch);
    if (ch == 0) return 0;
    return int'((cin >> (ch * 6)) & 24'h3F);
  endfunction

  // Reference behaviour for one clock edge, taken from the mode/interlock/reversal/aux rules.
  function automatic mst_t mstep(input mst_t s, input int sel, input logic [23:0] cin,
                                 input int dead_cycles, input int rev_gap);
    mst_t n;
    int eff, r, f, b, l, rt, aux, of, ob, ol, orr, pulse;
    n   = s;
    eff = (sel < 4) ? sel : 0;
    if (s.in_dead == 0) begin
      if (eff != s.active && dead_cycles > 0) begin
        n.in_dead  = 1;
        n.target   = eff;
        n.dead_cnt = dead_cycles;
        n.cmd_out  = 0;
      end else begin
        n.active = eff;
        r   = chan(cin, eff);
        f   = r & 1;
        b   = (r >> 1) & 1;
        l   = (r >> 2) & 1;
        rt  = (r >> 3) & 1;
        aux = (r >> 4) & 3;
        of  = (f != 0 && b == 0) ? 1 : 0;
        ob  = (b != 0 && f == 0) ? 1 : 0;
        ol  = (l != 0 && rt == 0) ? 1 : 0;
        orr = (rt != 0 && l == 0) ? 1 : 0;
        if (((f & b) != 0 || (l & rt) != 0) && s.conflict < 255) n.conflict = s.conflict + 1;
        if (rev_gap > 0 && (((s.cmd_out & 1) != 0 && ob == 1) || ((s.cmd_out & 2) != 0 && of == 1))) begin
          n.rev_cnt = rev_gap;
          of = 0;
          ob = 0;
        end else if (s.rev_cnt > 0) begin
          n.rev_cnt = s.rev_cnt - 1;
          of = 0;
          ob = 0;
        end
        pulse      = aux & ~s.aux_prev & 3;
        n.cmd_out  = of | (ob << 1) | (ol << 2) | (orr << 3) | (pulse << 4);
        n.aux_prev = aux;
      end
    end else begin
      n.cmd_out = 0;
      if (eff != s.target) begin
        n.target   = eff;
        n.dead_cnt = dead_cycles;
      end else if (s.dead_cnt == 1) begin
        n.in_dead  = 0;
        n.active   = s.target;
        n.rev_cnt  = 0;
        n.aux_prev = (chan(cin, s.target) >> 4) & 3;
      end else begin
        n.dead_cnt = s.dead_cnt - 1;
      end
    end
    n.switching = n.in_dead;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    mst_t n0, n1;
    n0 = mstep(m0, int'(mode_sel), cmd_in, 4, 2);
    n1 = mstep(m1, int'(mode_sel3), cmd_in, 0, 0);
    @(posedge clk);
    #1;
    m0 = n0;
    m1 = n1;
    chk("cmd_out", 32'(cmd_out0), m0.cmd_out);
    chk("active_mode", 32'(active0), m0.active);
    chk("switching", 32'(sw0), m0.switching);
    chk("conflict_cnt", 32'(cc0), m0.conflict);
    chk("cmd_out_nd", 32'(cmd_out3), m1.cmd_out);
    chk("active_mode_nd", 32'(active3), m1.active);
    chk("switching_nd", 32'(sw3), m1.switching);
    chk("conflict_cnt_nd", 32'(cc3), m1.conflict);
  endtask

  // Asserts reset between clock edges and checks that outputs clear before any edge.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_cmd_out", 32'(cmd_out0), 0);
    chk("rst_active_mode", 32'(active0), 0);
    chk("rst_switching", 32'(sw0), 0);
    chk("rst_conflict_cnt", 32'(cc0), 0);
    chk("rst_cmd_out_nd", 32'(cmd_out3), 0);
    chk("rst_active_mode_nd", 32'(active3), 0);
    m0 = '{default: 0};
    m1 = '{default: 0};
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_ch(input int k, input logic [5:0] v);
    cmd_in[k*6 +: 6] = v;
  endtask

  int cnt;

  initial begin
    reset     = 1'b0;
    mode_sel  = '0;
    mode_sel3 = '0;
    cmd_in    = '0;
    m0 = '{default: 0};
    m1 = '{default: 0};
    @(posedge clk);
    #1;
    apply_reset();

    // Mode change 0 -> 1: four cycles of dead time, then channel 1 drives.
    set_ch(1, 6'b000001);
    mode_sel = 2'd1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sw0) cnt++;
      if (i == 4) chk("t1_active_after_dead", 32'(active0), 1);
    end
    chk("t1_dead_cycles", cnt, 4);
    chk("t1_first_cmd", 32'(cmd_out0), 32'h01);

    // Forward+left to backward+left: longitudinal gap of 3 cycles, turn held.
    set_ch(1, 6'b000101);
    tick();
    set_ch(1, 6'b000110);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cmd_out0[1:0] == 2'b00 && cmd_out0[2] == 1'b1) cnt++;
    end
    chk("t2_gap_cycles", cnt, 3);
    chk("t2_after_gap", 32'(cmd_out0), 32'h06);

    // Opposing commands: zero output, counter saturates.
    set_ch(1, 6'b001111);
    for (int i = 0; i < 3; i++) tick();
    chk("t3_interlock_out", 32'(cmd_out0), 0);
    chk("t3_conflict_3", 32'(cc0), 3);
    for (int i = 0; i < 297; i++) tick();
    chk("t3_conflict_sat", 32'(cc0), 255);

    // Aux level held: exactly one pulse.
    set_ch(1, 6'b010000);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmd_out0[4]) cnt++;
    end
    chk("t4_aux_pulses", cnt, 1);

    // Entering a mode with aux already held: no pulse.
    set_ch(2, 6'b010000);
    mode_sel = 2'd2;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cmd_out0[4]) cnt++;
    end
    chk("t4_no_pulse_on_entry", cnt, 0);
    chk("t4_active", 32'(active0), 2);

    // Retarget mid dead time restarts the full count.
    set_ch(1, 6'b000001);
    set_ch(3, 6'b000100);
    mode_sel = 2'd1;
    for (int i = 0; i < 3; i++) tick();
    mode_sel = 2'd3;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sw0) cnt++;
    end
    chk("t5_restart_cycles", cnt, 4);
    chk("t5_active", 32'(active0), 3);
    chk("t5_cmd", 32'(cmd_out0), 32'h04);

    // Reset mid dead time.
    mode_sel = 2'd1;
    tick();
    tick();
    apply_reset();

    // Reset mid reversal.
    set_ch(1, 6'b000001);
    for (int i = 0; i < 6; i++) tick();
    set_ch(1, 6'b000010);
    tick();
    apply_reset();

    // Out-of-range selection on the 3-bit instance behaves as OFF.
    set_ch(0, 6'b111111);
    set_ch(1, 6'b000101);
    set_ch(2, 6'b000001);
    mode_sel3 = 3'd5;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_oor_cmd", 32'(cmd_out3), 0);
    chk("t6_oor_active", 32'(active3), 0);

    // Zero dead time: switch and drive on the same edge.
    mode_sel3 = 3'd2;
    tick();
    chk("t6_nodead_active", 32'(active3), 2);
    chk("t6_nodead_cmd", 32'(cmd_out3), 32'h01);

    // Randomized phase against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mode_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) mode_sel3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) set_ch($urandom_range(0, 3), 6'($urandom()));
      if ($urandom_range(0, 399) == 0) apply_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
